// File: rtl/rx_ctrl.sv
// rtl/rx_ctrl.sv - receive-path sequencer: loop reset, acquisition wait, sync gating, payload framing
//
// Purpose: owns recovery-loop reset and the payload window for the receiver.
//   IDLE -> ACQ (loops released, settle wait) -> SEARCH (await sync word)
//   -> DATA (count payload bits) -> GUARD (dead time) -> SEARCH or IDLE.
// Optional feature macro: RX_CTRL_SYNC_TIMEOUT_EN (bounds the SEARCH wait).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   RX_ACQ_CYCLES     loop settle time after signal detect (0 treated as 1)
//   RX_FRAME_BITS     payload bits per frame (0 treated as 1)
//   RX_GUARD_CYCLES   dead time after a frame (0 treated as 1)
//   RX_SYNC_TIMEOUT   sync search limit, 0 = none (only with the macro)
//   SD_flag           signal-present level
//   sync_found        sync word matched, 1-cycle pulse
//   bit_vld           demodulated bit strobe, 1-cycle pulse
//   loop_rst          recovery loops held in reset (level)
//   data_en           payload window (level)
//   frame_start       first cycle of payload window (pulse)
//   frame_end         frame completed (pulse)
//   frame_abort       frame or search abandoned (pulse)
//   state             current state encoding (debug)

module rx_ctrl #(
  parameter int ACQ_WIDTH = 16,
  parameter int LEN_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ACQ_WIDTH-1:0] RX_ACQ_CYCLES,
  input  logic [LEN_WIDTH-1:0] RX_FRAME_BITS,
  input  logic [ACQ_WIDTH-1:0] RX_GUARD_CYCLES,
  input  logic [ACQ_WIDTH-1:0] RX_SYNC_TIMEOUT,
  input  logic                 SD_flag,
  input  logic                 sync_found,
  input  logic                 bit_vld,
  output logic                 loop_rst,
  output logic                 data_en,
  output logic                 frame_start,
  output logic                 frame_end,
  output logic                 frame_abort,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACQ    = 3'd1,
    S_SEARCH = 3'd2,
    S_DATA   = 3'd3,
    S_GUARD  = 3'd4
  } state_t;

  state_t               r_state;
  logic [ACQ_WIDTH-1:0] r_cnt;
  logic [LEN_WIDTH-1:0] r_bits;
  logic                 r_loop_rst;
  logic                 r_data_en;
  logic                 r_frame_start;
  logic                 r_frame_end;
  logic                 r_frame_abort;

  // Incremented values carry one extra bit so the compare can never wrap.
  // Comparing "count+1 >= limit" makes a zero limit behave as one cycle/bit.
  logic [ACQ_WIDTH:0]   w_cnt_inc;
  logic [LEN_WIDTH:0]   w_bits_inc;
  logic                 w_acq_done;
  logic                 w_guard_done;
  logic                 w_last_bit;
  logic                 w_cnt_sat;

  assign w_cnt_inc    = {1'b0, r_cnt} + 1'b1;
  assign w_bits_inc   = {1'b0, r_bits} + 1'b1;
  assign w_acq_done   = (w_cnt_inc >= {1'b0, RX_ACQ_CYCLES});
  assign w_guard_done = (w_cnt_inc >= {1'b0, RX_GUARD_CYCLES});
  assign w_last_bit   = (w_bits_inc >= {1'b0, RX_FRAME_BITS});
  assign w_cnt_sat    = &r_cnt;

`ifdef RX_CTRL_SYNC_TIMEOUT_EN
  logic w_timeout;
  assign w_timeout = (RX_SYNC_TIMEOUT != '0) && (w_cnt_inc >= {1'b0, RX_SYNC_TIMEOUT});
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^RX_SYNC_TIMEOUT;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_bits        <= '0;
      r_loop_rst    <= 1'b1;
      r_data_en     <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_frame_abort <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_frame_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_loop_rst <= 1'b1;
          r_data_en  <= 1'b0;
          if (SD_flag) begin
            r_state    <= S_ACQ;
            r_cnt      <= '0;
            r_loop_rst <= 1'b0;
          end
        end

        S_ACQ: begin
          if (!SD_flag) begin
            r_state    <= S_IDLE;
            r_loop_rst <= 1'b1;
          end else if (w_acq_done) begin
            r_state <= S_SEARCH;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_SEARCH: begin
          // Signal loss outranks a sync hit; a hit outranks the timeout.
          if (!SD_flag) begin
            r_state    <= S_IDLE;
            r_loop_rst <= 1'b1;
          end else if (sync_found) begin
            r_state       <= S_DATA;
            r_bits        <= '0;
            r_data_en     <= 1'b1;
            r_frame_start <= 1'b1;
`ifdef RX_CTRL_SYNC_TIMEOUT_EN
          end else if (w_timeout) begin
            r_state       <= S_IDLE;
            r_loop_rst    <= 1'b1;
            r_frame_abort <= 1'b1;
          end else if (!w_cnt_sat) begin
            r_cnt <= r_cnt + 1'b1;
`endif
          end
        end

        S_DATA: begin
          // The final bit completes the frame even if signal drops with it.
          if (bit_vld && w_last_bit) begin
            r_state     <= S_GUARD;
            r_cnt       <= '0;
            r_data_en   <= 1'b0;
            r_frame_end <= 1'b1;
          end else if (!SD_flag) begin
            r_state       <= S_IDLE;
            r_loop_rst    <= 1'b1;
            r_data_en     <= 1'b0;
            r_frame_abort <= 1'b1;
          end else if (bit_vld) begin
            r_bits <= w_bits_inc[LEN_WIDTH-1:0];
          end
        end

        S_GUARD: begin
          if (w_guard_done) begin
            r_cnt <= '0;
            if (SD_flag) begin
              r_state <= S_SEARCH;
            end else begin
              r_state    <= S_IDLE;
              r_loop_rst <= 1'b1;
            end
          end else if (!w_cnt_sat) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_loop_rst <= 1'b1;
          r_data_en  <= 1'b0;
        end
      endcase
    end
  end

  assign loop_rst    = r_loop_rst;
  assign data_en     = r_data_en;
  assign frame_start = r_frame_start;
  assign frame_end   = r_frame_end;
  assign frame_abort = r_frame_abort;
  assign state       = r_state;

endmodule
